// File: rtl/vdg_cell_shifter.sv
// Character-cell pixel generator: resolves one display byte per cell (alpha glyph row or SG4 block)
// and serialises it into 9-bit RGB pixels at a programmable pixel rate.
module vdg_cell_shifter #(
   parameter int CELL_WIDTH = 8,
   parameter int CELL_ROWS  = 12,
   parameter int GLYPH_TOP  = 3,
   parameter int GLYPH_ROWS = 7,
   parameter int DIV_W      = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          load,
   input  logic [7:0]                    code,
   input  logic [$clog2(CELL_ROWS)-1:0]  row,
   input  logic                          css,
   input  logic                          blank,
   input  logic [DIV_W-1:0]              divider,
   output logic [5:0]                    rom_index,
   output logic [$clog2(GLYPH_ROWS)-1:0] rom_row,
   input  logic [CELL_WIDTH-1:0]         rom_data,
   output logic [8:0]                    rgb,
   output logic                          cell_done
);

   localparam int ROW_W  = $clog2(CELL_ROWS);
   localparam int GROW_W = $clog2(GLYPH_ROWS);
   localparam int PIX_W  = $clog2(CELL_WIDTH);
   localparam int HALF   = CELL_WIDTH / 2;

   localparam logic [ROW_W:0]   L_GTOP   = (ROW_W+1)'(GLYPH_TOP);
   localparam logic [ROW_W:0]   L_GEND   = (ROW_W+1)'(GLYPH_TOP + GLYPH_ROWS);
   localparam logic [ROW_W:0]   L_ROWS   = (ROW_W+1)'(CELL_ROWS);
   localparam logic [ROW_W:0]   L_HALF   = (ROW_W+1)'(CELL_ROWS / 2);
   localparam logic [ROW_W-1:0] L_GTOP_S = ROW_W'(GLYPH_TOP);
   localparam logic [PIX_W-1:0] L_LAST   = PIX_W'(CELL_WIDTH - 1);
   localparam logic [PIX_W-1:0] L_PENULT = PIX_W'(CELL_WIDTH - 2);

   // stage 1: sampled cell attributes
   logic                 r_s1_valid;
   logic [7:0]           r_code;
   logic [ROW_W-1:0]     r_row;
   logic                 r_css;
   logic                 r_blank;
   logic [DIV_W-1:0]     r_div;

   // stage 2: running cell
   logic [CELL_WIDTH-2:0] r_shift;
   logic [8:0]            r_fg;
   logic [8:0]            r_bg;
   logic [8:0]            r_rgb;
   logic [DIV_W-1:0]      r_cell_div;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [PIX_W-1:0]      r_pix_cnt;
   logic                  r_active;
   logic                  r_done;

   logic [ROW_W:0]        w_row_ext;
   logic                  w_glyph_line;
   logic                  w_upper;
   logic                  w_sg_left;
   logic                  w_sg_right;
   logic [CELL_WIDTH-1:0] w_sg_pat;
   logic [CELL_WIDTH-1:0] w_inv_mask;
   logic [CELL_WIDTH-1:0] w_pattern;
   logic [8:0]            w_fg;
   logic [8:0]            w_bg;
   logic [8:0]            w_first_rgb;

   assign w_row_ext    = {1'b0, r_row};
   assign w_glyph_line = (w_row_ext >= L_GTOP) && (w_row_ext < L_GEND) && (w_row_ext < L_ROWS);
   assign w_upper      = (w_row_ext < L_HALF);

   assign rom_index = r_code[5:0];
   assign rom_row   = w_glyph_line ? GROW_W'(r_row - L_GTOP_S) : '0;

   assign w_sg_left  = w_upper ? r_code[3] : r_code[1];
   assign w_sg_right = w_upper ? r_code[2] : r_code[0];

   genvar gi;
   generate
      for (gi = 0; gi < CELL_WIDTH; gi++) begin : g_sg_pix
         if (gi >= HALF) begin : g_left
            assign w_sg_pat[gi] = w_sg_left;
         end else begin : g_right
            assign w_sg_pat[gi] = w_sg_right;
         end
      end
   endgenerate

   assign w_inv_mask = {CELL_WIDTH{r_code[6]}};
   assign w_pattern  = r_code[7]    ? w_sg_pat :
                       w_glyph_line ? (rom_data ^ w_inv_mask) : w_inv_mask;

   always_comb begin
      w_fg = 9'b000_111_000;
      w_bg = 9'b000_010_000;
      if (r_code[7]) begin
         w_bg = 9'b000_000_000;
         case (r_code[6:4])
            3'd0:    w_fg = 9'b000_111_000;
            3'd1:    w_fg = 9'b111_111_000;
            3'd2:    w_fg = 9'b000_000_111;
            3'd3:    w_fg = 9'b111_000_000;
            3'd4:    w_fg = 9'b111_111_111;
            3'd5:    w_fg = 9'b000_111_111;
            3'd6:    w_fg = 9'b111_000_111;
            default: w_fg = 9'b111_100_000;
         endcase
      end else if (r_css) begin
         w_fg = 9'b111_100_000;
         w_bg = 9'b010_001_000;
      end
   end

   assign w_first_rgb = r_blank ? 9'd0 : (w_pattern[CELL_WIDTH-1] ? w_fg : w_bg);

   // A pending stage-2 load always wins over the running cell, which drops any cell_done it still owed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_code     <= '0;
         r_row      <= '0;
         r_css      <= 1'b0;
         r_blank    <= 1'b0;
         r_div      <= '0;
         r_shift    <= '0;
         r_fg       <= '0;
         r_bg       <= '0;
         r_rgb      <= '0;
         r_cell_div <= '0;
         r_div_cnt  <= '0;
         r_pix_cnt  <= '0;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_s1_valid <= load;
         if (load) begin
            r_code  <= code;
            r_row   <= row;
            r_css   <= css;
            r_blank <= blank;
            r_div   <= divider;
         end

         r_done <= 1'b0;
         if (r_s1_valid) begin
            r_shift    <= w_pattern[CELL_WIDTH-2:0];
            r_fg       <= r_blank ? 9'd0 : w_fg;
            r_bg       <= r_blank ? 9'd0 : w_bg;
            r_rgb      <= w_first_rgb;
            r_cell_div <= r_div;
            r_div_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_active   <= 1'b1;
         end else if (r_active) begin
            if (r_div_cnt == r_cell_div) begin
               r_div_cnt <= '0;
               if (r_pix_cnt == L_LAST) begin
                  r_active <= 1'b0;
                  r_rgb    <= r_bg;
               end else begin
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                  r_shift   <= {r_shift[CELL_WIDTH-3:0], 1'b0};
                  r_rgb     <= r_shift[CELL_WIDTH-2] ? r_fg : r_bg;
                  if (r_pix_cnt == L_PENULT) begin
                     r_done <= 1'b1;
                  end
               end
            end else begin
               r_div_cnt <= r_div_cnt + 1'b1;
            end
         end
      end
   end

   assign rgb       = r_rgb;
   assign cell_done = r_done;

endmodule

// File: tb/tb_vdg_cell_shifter.sv
// Directed bench for vdg_cell_shifter: a table of single cells plus hand sequences for
// back-to-back cells, preemption and mid-cell reset.
module tb_vdg_cell_shifter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       load;
   logic [7:0] code;
   logic [3:0] row;
   logic       css;
   logic       blank;
   logic [1:0] divider;
   logic [5:0] rom_index;
   logic [2:0] rom_row;
   logic [7:0] rom_data;
   logic [8:0] rgb;
   logic       cell_done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [7:0] code;
      logic [3:0] row;
      logic       css;
      logic       blank;
      logic [1:0] div;
      logic [7:0] rom;
      logic [7:0] emask;   // expected fg/bg choice per pixel, MSB = first pixel
      logic [8:0] efg;
      logic [8:0] ebg;     // also the idle colour after the cell ends
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   vdg_cell_shifter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .code      (code),
      .row       (row),
      .css       (css),
      .blank     (blank),
      .divider   (divider),
      .rom_index (rom_index),
      .rom_row   (rom_row),
      .rom_data  (rom_data),
      .rgb       (rgb),
      .cell_done (cell_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_cell(input vec_t v, input int id);
      int       errs0;
      logic [8:0] e;
      errs0    = n_errors;
      code     = v.code;
      row      = v.row;
      css      = v.css;
      blank    = v.blank;
      divider  = v.div;
      rom_data = v.rom;
      load     = 1'b1;
      tick();
      load    = 1'b0;
      code    = ~v.code;
      divider = ~v.div;
      check("rom_index", int'(rom_index), int'(v.code[5:0]));
      if (v.row >= 4'd3 && v.row <= 4'd9 && !v.code[7])
         check("rom_row", int'(rom_row), int'(v.row) - 3);
      tick();
      rom_data = ~v.rom;
      for (int k = 0; k < 8; k++) begin
         e = v.emask[7-k] ? v.efg : v.ebg;
         for (int d = 0; d <= int'(v.div); d++) begin
            check("pixel", int'(rgb), int'(e));
            check("cell_done", int'(cell_done), (k == 7 && d == 0) ? 1 : 0);
            tick();
         end
      end
      check("idle_rgb", int'(rgb), int'(v.ebg));
      check("idle_done", int'(cell_done), 0);
      $display("cell %0d: code=%02h row=%0d css=%0d blank=%0d div=%0d errors_in_cell=%0d",
               id, v.code, v.row, v.css, v.blank, v.div, n_errors - errs0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      //                code   row  css   blk   div   rom    mask   fg      bg
      vecs[0]  = '{8'h01, 4'd3,  1'b0, 1'b0, 2'd0, 8'h38, 8'h38, 9'h038, 9'h010};
      vecs[1]  = '{8'h41, 4'd0,  1'b1, 1'b0, 2'd0, 8'h5A, 8'hFF, 9'h1E0, 9'h088};
      vecs[2]  = '{8'hB9, 4'd2,  1'b0, 1'b0, 2'd0, 8'h00, 8'hF0, 9'h1C0, 9'h000};
      vecs[3]  = '{8'hB9, 4'd8,  1'b0, 1'b0, 2'd0, 8'h00, 8'h0F, 9'h1C0, 9'h000};
      vecs[4]  = '{8'hFF, 4'd5,  1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, 9'h000, 9'h000};
      vecs[5]  = '{8'h41, 4'd4,  1'b0, 1'b0, 2'd0, 8'h81, 8'h7E, 9'h038, 9'h010};
      vecs[6]  = '{8'h01, 4'd10, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 9'h038, 9'h010};
      vecs[7]  = '{8'h02, 4'd9,  1'b1, 1'b0, 2'd0, 8'hF0, 8'hF0, 9'h1E0, 9'h088};
      vecs[8]  = '{8'h00, 4'd14, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 9'h038, 9'h010};
      vecs[9]  = '{8'hC6, 4'd5,  1'b0, 1'b0, 2'd0, 8'h00, 8'h0F, 9'h1FF, 9'h000};
      vecs[10] = '{8'hC6, 4'd6,  1'b0, 1'b0, 2'd0, 8'h00, 8'hF0, 9'h1FF, 9'h000};
      vecs[11] = '{8'h01, 4'd3,  1'b0, 1'b0, 2'd3, 8'h38, 8'h38, 9'h038, 9'h010};
      vecs[12] = '{8'h8F, 4'd0,  1'b1, 1'b0, 2'd1, 8'h00, 8'hFF, 9'h038, 9'h000};
      vecs[13] = '{8'h3F, 4'd3,  1'b1, 1'b0, 2'd2, 8'hA5, 8'hA5, 9'h1E0, 9'h088};

      reset_n = 1'b0; load = 1'b0; code = '0; row = '0; css = 1'b0;
      blank = 1'b0; divider = '0; rom_data = '0;
      tick(); tick(); tick();
      check("reset_rgb", int'(rgb), 0);
      check("reset_done", int'(cell_done), 0);
      check("reset_rom_index", int'(rom_index), 0);
      check("reset_rom_row", int'(rom_row), 0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < NVEC; i++) begin
         run_cell(vecs[i], i);
         tick();
      end

      // back-to-back cells, divider=1, second load issued in the cell_done cycle
      code = 8'h01; row = 4'd3; css = 1'b0; blank = 1'b0; divider = 2'd1; rom_data = 8'h38;
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      c = 0;
      while (!cell_done && c < 40) begin tick(); c++; end
      check("b2b_first_done_time", c, 14);
      check("b2b_last_pixel_a0", int'(rgb), 9'h010);
      code = 8'h41; row = 4'd0; css = 1'b1; divider = 2'd1; load = 1'b1;
      tick();
      load = 1'b0;
      check("b2b_last_pixel_a1", int'(rgb), 9'h010);
      check("b2b_no_done_gap", int'(cell_done), 0);
      tick();
      check("b2b_first_pixel_b", int'(rgb), 9'h1E0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("b2b_pixel_b", int'(rgb), 9'h1E0);
         check("b2b_done_b", int'(cell_done), (i == 14) ? 1 : 0);
      end
      tick();
      check("b2b_idle_b", int'(rgb), 9'h088);
      $display("sequence back_to_back: errors so far=%0d", n_errors);

      // preemption: new blank cell loaded while the first is still shifting
      code = 8'h01; row = 4'd3; css = 1'b0; blank = 1'b0; divider = 2'd0; rom_data = 8'h38;
      load = 1'b1;
      tick(); load = 1'b0;
      tick(); tick(); tick();
      check("pre_pixel2", int'(rgb), 9'h038);
      code = 8'hFF; row = 4'd5; blank = 1'b1; load = 1'b1;
      tick(); load = 1'b0; blank = 1'b0;
      check("pre_pixel3", int'(rgb), 9'h038);
      tick();
      check("pre_new_first", int'(rgb), 0);
      check("pre_new_first_done", int'(cell_done), 0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("pre_new_pixel", int'(rgb), 0);
         check("pre_done", int'(cell_done), (i == 7) ? 1 : 0);
      end
      $display("sequence preempt: errors so far=%0d", n_errors);

      // reset mid-cell abandons it
      code = 8'h01; row = 4'd3; css = 1'b0; blank = 1'b0; divider = 2'd0; rom_data = 8'h38;
      load = 1'b1;
      tick(); load = 1'b0;
      tick(); tick();
      check("rst_pixel1", int'(rgb), 9'h010);
      reset_n = 1'b0;
      tick();
      check("rst_rgb", int'(rgb), 0);
      check("rst_done", int'(cell_done), 0);
      check("rst_rom_index", int'(rom_index), 0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_quiet_done", int'(cell_done), 0);
         check("rst_quiet_rgb", int'(rgb), 0);
      end
      $display("sequence reset_mid_cell: errors so far=%0d", n_errors);
      run_cell(vecs[0], 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
